// File: rtl/tick_countdown_timer_pkg.sv
// tick_countdown_timer_pkg: state encoding and default count width for the countdown timer.
package tick_countdown_timer_pkg;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSE   = 2'd2,
    S_EXPIRED = 2'd3
  } state_e;
endpackage

// File: rtl/tick_countdown_timer.sv
// tick_countdown_timer: tick-driven down-counter with start/pause/resume/cancel and expiry pulse.
module tick_countdown_timer
  import tick_countdown_timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             cancel,
  output logic [CNT_W-1:0] remaining,
  output logic             running,
  output logic             paused,
  output logic             done,
  output logic             expired
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             go, hold;
  assign go   = start & ~pause;
  assign hold = pause & ~start;
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    if (cancel) begin
      state_d = S_IDLE;
      rem_d   = '0;
    end else if (load) begin
      state_d = S_IDLE;
      rem_d   = load_val;
    end else begin
      case (state_q)
        S_IDLE:  state_d = (go && rem_q != '0) ? S_RUN : S_IDLE;
        S_PAUSE: state_d = go ? S_RUN : S_PAUSE;
        S_RUN: begin
          if (hold) begin
            state_d = S_PAUSE;
          end else if (tick && rem_q != '0) begin
            // Reaching zero is the only way into EXPIRED, so done fires exactly once.
            rem_d   = rem_q - 1'b1;
            state_d = (rem_q == CNT_W'(1)) ? S_EXPIRED : S_RUN;
            done_d  = (rem_q == CNT_W'(1));
          end
        end
        default: state_d = state_q;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end
  assign remaining = rem_q;
  assign running   = (state_q == S_RUN);
  assign paused    = (state_q == S_PAUSE);
  assign expired   = (state_q == S_EXPIRED);
  assign done      = done_q;
endmodule

// File: tb/tb_tick_countdown_timer.sv
// tb_tick_countdown_timer: directed and random checks of a 16-bit and a 4-bit timer against a behavioural model.
module tb_tick_countdown_timer;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, cancel = 1'b0;
  logic [15:0] load_val = '0;
  logic [3:0]  load_val4;
  logic [15:0] rem_a;
  logic [3:0]  rem_b;
  logic        run_a, pau_a, done_a, exp_a, run_b, pau_b, done_b, exp_b;
  int          n_assert = 0, n_fail = 0;
  int          m_rem[2], m_st[2];
  int          m_done[2];
  int          mx[2] = '{65535, 15};
  localparam int IDLE = 0, RUN = 1, PAUSE = 2, EXP = 3;

  assign load_val4 = load_val[3:0];
  always #5 clk = ~clk;

  tick_countdown_timer #(.CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .tick(tick), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .cancel(cancel), .remaining(rem_a),
    .running(run_a), .paused(pau_a), .done(done_a), .expired(exp_a));
  tick_countdown_timer #(.CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick(tick), .load(load), .load_val(load_val4),
    .start(start), .pause(pause), .cancel(cancel), .remaining(rem_b),
    .running(run_b), .paused(pau_b), .done(done_b), .expired(exp_b));

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int k = 0; k < 2; k++) begin
      m_rem[k] = 0; m_st[k] = IDLE; m_done[k] = 0;
    end
  endfunction

  function automatic void m_step(input int k);
    m_done[k] = 0;
    if (cancel) begin
      m_rem[k] = 0; m_st[k] = IDLE;
    end else if (load) begin
      m_rem[k] = int'(load_val) % (mx[k] + 1); m_st[k] = IDLE;
    end else if (m_st[k] == IDLE) begin
      if (start && !pause && m_rem[k] > 0) m_st[k] = RUN;
    end else if (m_st[k] == PAUSE) begin
      if (start && !pause) m_st[k] = RUN;
    end else if (m_st[k] == RUN) begin
      if (pause && !start) m_st[k] = PAUSE;
      else if (tick && m_rem[k] > 0) begin
        m_rem[k] = m_rem[k] - 1;
        if (m_rem[k] == 0) begin
          m_st[k] = EXP; m_done[k] = 1;
        end
      end
    end
  endfunction

  task automatic cmp_all();
    chk("a.remaining", int'(rem_a), m_rem[0]);
    chk("a.running", int'(run_a), int'(m_st[0] == RUN));
    chk("a.paused", int'(pau_a), int'(m_st[0] == PAUSE));
    chk("a.expired", int'(exp_a), int'(m_st[0] == EXP));
    chk("a.done", int'(done_a), m_done[0]);
    chk("b.remaining", int'(rem_b), m_rem[1]);
    chk("b.running", int'(run_b), int'(m_st[1] == RUN));
    chk("b.paused", int'(pau_b), int'(m_st[1] == PAUSE));
    chk("b.expired", int'(exp_b), int'(m_st[1] == EXP));
    chk("b.done", int'(done_b), m_done[1]);
  endtask

  task automatic step(input logic t, input logic l, input int lv, input logic s,
                      input logic p, input logic c);
    tick = t; load = l; load_val = 16'(lv); start = s; pause = p; cancel = c;
    @(posedge clk);
    m_step(0); m_step(1);
    #1;
    cmp_all();
    tick = 0; load = 0; start = 0; pause = 0; cancel = 0;
  endtask

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp_all();
    rst_n = 1'b1;
    // Reset mid-count, asserted between edges
    step(0, 1, 5, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst.pre_remaining", int'(rem_a), 3);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("rst.async_remaining", int'(rem_a), 0);
    chk("rst.async_running", int'(run_a), 0);
    @(negedge clk) rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    // Normal expiry
    step(0, 1, 3, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    for (int i = 2; i >= 0; i--) begin
      step(1, 0, 0, 0, 0, 0);
      chk("exp.count", int'(rem_a), i);
      chk("exp.done", int'(done_a), int'(i == 0));
    end
    chk("exp.expired", int'(exp_a), 1);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    chk("exp.no_refire", int'(done_a), 0);
    // Pause/resume
    step(0, 1, 4, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    repeat (5) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    chk("pause.hold", int'(rem_a), 3);
    chk("pause.flag", int'(pau_a), 1);
    step(1, 0, 0, 1, 0, 0);
    chk("pause.resume_no_tick", int'(rem_a), 3);
    repeat (3) step(1, 0, 0, 0, 0, 0);
    chk("pause.expired", int'(exp_a), 1);
    // Coincidence
    step(0, 1, 2, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    chk("coin.start_tick", int'(rem_a), 2);
    step(1, 0, 0, 0, 1, 0);
    chk("coin.pause_tick", int'(rem_a), 2);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 1);
    chk("coin.cancel_tick", int'(rem_a), 0);
    // Guard and priority
    step(0, 0, 0, 1, 0, 0);
    chk("guard.start_zero", int'(run_a), 0);
    step(0, 1, 7, 0, 0, 1);
    chk("prio.load_cancel", int'(rem_a), 0);
    step(0, 1, 6, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 1, 9, 0, 0, 0);
    chk("prio.load_run", int'(rem_a), 9);
    chk("prio.load_run_idle", int'(run_a), 0);
    // Width boundary on the 4-bit instance
    step(0, 1, 15, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    for (int i = 14; i >= 0; i--) begin
      step(1, 0, 0, 0, 0, 0);
      chk("w4.count", int'(rem_b), i);
      chk("w4.done", int'(done_b), int'(i == 0));
    end
    step(1, 0, 0, 0, 0, 0);
    chk("w4.no_wrap", int'(rem_b), 0);
    step(0, 1, 16'hffff, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("w16.max", int'(rem_a), 65534);
    // Random traffic
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(0, 1)), $urandom_range(0, 99) < 6, int'($urandom_range(0, 20)),
           $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 3);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
